// File: rtl/bpu_pkg.sv
// Shared types for the branch resolve unit: the in-flight branch record and
// direction encodings.
package bpu_pkg;

  // Stored address width; ports narrower/wider than this are cast at the top.
  localparam int BR_AW = 32;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_BWD = 1'b1;

  typedef struct packed {
    logic [BR_AW-1:0] pc;
    logic [BR_AW-1:0] target;
    logic             dir;
    logic             taken;
  } br_rec_t;

endpackage

// File: rtl/bru_fifo.sv
// Circular FIFO of in-flight branch predictions with a synchronous clear that
// drops every entry (used on mispredict).
module bru_fifo
  import bpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  logic    clear,
  input  br_rec_t entry,
  output logic    full,
  output logic    empty,
  output br_rec_t head
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  br_rec_t         mem [DEPTH];
  logic [PW-1:0]   rptr, wptr;
  logic [CW-1:0]   count;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rptr];

  // Pointer arithmetic relies on DEPTH being a power of two to wrap for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (clear) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wptr] <= entry;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves predicted branches at execute against the actual outcome; raises a
// flush/redirect on mispredict and trains the predictor. Optional counters: BRU_STATS_EN.
module branch_resolve_unit
  import bpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  PredValidF,
  input  logic [DATA_WIDTH-1:0] PredPCF,
  input  logic [DATA_WIDTH-1:0] PredTargetF,
  input  logic                  PredTakenF,
  input  logic                  PredDirF,
  input  logic                  BranchE,
  input  logic                  ZeroE,
  output logic                  flushBranch,
  output logic [DATA_WIDTH-1:0] PCRedirect,
  output logic                  PCRedirectSrc,
  output logic                  UpdateValid,
  output logic                  UpdateDir,
  output logic                  UpdateCorrect,
  output logic                  QueueFull,
  output logic                  QueueEmpty,
  output logic                  ResolveErr
`ifdef BRU_STATS_EN
  ,
  output logic [31:0]           BranchCount,
  output logic [31:0]           MispredCount
`endif
);
  br_rec_t entry, head;
  logic    full, empty, pop, push;
  logic [DATA_WIDTH-1:0] head_pc, head_tgt;

  always_comb begin
    entry        = '0;
    entry.pc     = BR_AW'(PredPCF);
    entry.target = BR_AW'(PredTargetF);
    entry.dir    = PredDirF;
    entry.taken  = PredTakenF;
  end

  assign head_pc  = DATA_WIDTH'(head.pc);
  assign head_tgt = DATA_WIDTH'(head.target);

  assign pop         = BranchE && !empty;
  assign flushBranch = pop && (head.taken != ZeroE);
  // A push in the mispredict cycle is wrong-path and is dropped.
  assign push        = PredValidF && (!full || pop) && !flushBranch;

  assign PCRedirectSrc = flushBranch;
  assign PCRedirect    = !flushBranch ? '0 :
                         ZeroE        ? head_tgt : head_pc + DATA_WIDTH'(4);
  assign QueueFull     = full;
  assign QueueEmpty    = empty;

  bru_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (flushBranch),
    .entry (entry),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      UpdateValid   <= 1'b0;
      UpdateDir     <= 1'b0;
      UpdateCorrect <= 1'b0;
      ResolveErr    <= 1'b0;
    end else begin
      UpdateValid <= pop;
      if (pop) begin
        UpdateDir     <= head.dir;
        UpdateCorrect <= (head.taken == ZeroE);
      end
      if ((BranchE && empty) || (PredValidF && full && !pop)) ResolveErr <= 1'b1;
    end
  end

`ifdef BRU_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      BranchCount  <= '0;
      MispredCount <= '0;
    end else begin
      if (pop && BranchCount != '1)          BranchCount  <= BranchCount + 32'd1;
      if (flushBranch && MispredCount != '1) MispredCount <= MispredCount + 32'd1;
    end
  end
`endif

endmodule
